// File: rtl/sseg_scan_ctrl_if.sv
// Value/control in, per-slot decoder drive out, for the 7-segment scan controller.
interface sseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_en;
  logic [3:0]              hex;
  logic                    dp;
  logic                    en;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output value, dp_in, load, blank_en,
    input  hex, dp, en, digit_sel, frame_done
  );

  modport slave (
    input  value, dp_in, load, blank_en,
    output hex, dp, en, digit_sel, frame_done
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed digit scanner: one digit per refresh slot, dead-time blank at
// each slot start, optional leading-zero suppression, registered outputs.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic             clk,
  input  logic             reset,
  sseg_scan_ctrl_if.slave  bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] nib_t;

  logic [PW-1:0]         p_q, p_d;
  logic [DW-1:0]         d_q, d_d;
  nib_t                  sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                  frame_pend_q, frame_pend_d;

  logic [3:0]            hex_q, hex_d;
  logic                  dp_q, dp_d, en_q, en_d, fd_q, fd_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  slot_end, in_dead, tail_zero;
  logic [NUM_DIGITS-1:0] supp_vec;

  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (p_q < PW'(DEAD_CYCLES));
    end
  endgenerate

  // Digit i is a leading zero when it and every more significant digit has a
  // zero nibble and no decimal point; digit 0 is always shown.
  always_comb begin
    supp_vec  = '0;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero & (act_val_q[i] == 4'h0) & ~act_dp_q[i];
      if (i != 0) supp_vec[i] = tail_zero;
    end
  end

  always_comb begin
    slot_end = (p_q == P_LAST);
    p_d      = slot_end ? '0 : p_q + 1'b1;
    d_d      = d_q;
    if (slot_end) d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;

    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    if (bus.load) begin
      sh_val_d = bus.value;
      sh_dp_d  = bus.dp_in;
    end

    // Active only follows the shadow at a slot boundary, so a load never
    // disturbs the digit currently on the display.
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (slot_end) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
    end

    frame_pend_d = slot_end && (d_q == D_LAST);
    fd_d         = frame_pend_q;

    hex_d = 4'h0;
    dp_d  = 1'b0;
    en_d  = 1'b0;
    sel_d = '0;
    if (!in_dead) begin
      sel_d = NUM_DIGITS'(1) << d_q;
      if (!(bus.blank_en && supp_vec[d_q])) begin
        hex_d = act_val_q[d_q];
        dp_d  = act_dp_q[d_q];
        en_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q          <= '0;
      d_q          <= '0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      frame_pend_q <= 1'b0;
      hex_q        <= 4'h0;
      dp_q         <= 1'b0;
      en_q         <= 1'b0;
      sel_q        <= '0;
      fd_q         <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      frame_pend_q <= frame_pend_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      en_q         <= en_d;
      sel_q        <= sel_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.hex        = hex_q;
  assign bus.dp         = dp_q;
  assign bus.en         = en_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles)
// plus a zero-dead-time instance watched during free run.
module tb_sseg_scan_ctrl;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  sseg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();
  sseg_scan_ctrl_if #(.NUM_DIGITS(4)) bus0 ();

  sseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  sseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {bus.frame_done, bus.digit_sel, bus.en, bus.dp, bus.hex};
  endfunction

  // One full slot: 2 blank outputs then 6 drive outputs; optional load pulse
  // driven after iteration ld_at so it is sampled on the next edge.
  task automatic check_slot(input string tag, input int dig, input logic [3:0] hx,
                            input logic dpv, input logic env, input logic fdv,
                            input int ld_at, input logic [15:0] lv, input logic [3:0] ldp);
    logic [10:0] exp;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == ld_at + 1) bus.load = 1'b0;
      if (i < 2) exp = {(i == 0) ? fdv : 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0};
      else       exp = {1'b0, 4'(1 << dig), env, dpv, hx};
      chk($sformatf("%s_p%0d", tag, i), 32'(obs()), 32'(exp));
      if (i == ld_at) begin
        bus.load  = 1'b1;
        bus.value = lv;
        bus.dp_in = ldp;
      end
    end
  endtask

  initial begin
    int last_fd, first_fd, nfd, nmulti, nzero0, nen0;
    rst = 1'b1;
    bus.value = '0;  bus.dp_in = '0;  bus.load = 1'b0;  bus.blank_en = 1'b0;
    bus0.value = '0; bus0.dp_in = '0; bus0.load = 1'b0; bus0.blank_en = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_%0d", i), 32'(obs()), 32'd0);
    end
    rst = 1'b0;

    // Power-up scan, then a mid-slot load that must wait for the next boundary.
    check_slot("pu_d0", 0, 4'h0, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("ld_d1", 1, 4'h0, 1'b0, 1'b1, 1'b0,  3, 16'h1234, 4'b0010);
    check_slot("ld_d2", 2, 4'h2, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("ld_d3", 3, 4'h1, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("ld_d0", 0, 4'h4, 1'b0, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    bus.blank_en = 1'b1;
    check_slot("ld_d1b", 1, 4'h3, 1'b1, 1'b1, 1'b0, 3, 16'h0050, 4'b0000);

    // Leading-zero suppression, then a decimal point that stops it.
    check_slot("lz_d2", 2, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    check_slot("lz_d3", 3, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    check_slot("lz_d0", 0, 4'h0, 1'b0, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    check_slot("lz_d1", 1, 4'h5, 1'b0, 1'b1, 1'b0,  3, 16'h0050, 4'b0100);
    check_slot("lzdp_d2", 2, 4'h0, 1'b1, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("lzdp_d3", 3, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    check_slot("lzdp_d0", 0, 4'h0, 1'b0, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    check_slot("lzdp_d1", 1, 4'h5, 1'b0, 1'b1, 1'b0,  3, 16'h1111, 4'b0000);

    // Load on the boundary edge: active takes the old shadow first.
    check_slot("bnd_d2", 2, 4'h1, 1'b0, 1'b1, 1'b0,  6, 16'hAAAA, 4'b0000);
    check_slot("bnd_d3", 3, 4'h1, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("bnd_d0", 0, 4'hA, 1'b0, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    check_slot("bnd_d1", 1, 4'hA, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);

    // Reset at p=5 of digit 2.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mr_d2_p%0d", i), 32'(obs()),
          (i < 2) ? 32'd0 : 32'({1'b0, 4'b0100, 1'b1, 1'b0, 4'hA}));
    end
    rst = 1'b1;
    tick();
    chk("mr_clear", 32'(obs()), 32'd0);
    rst = 1'b0;
    check_slot("mr_d0", 0, 4'h0, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("mr_d1", 1, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    check_slot("mr_d2", 2, 4'h0, 1'b0, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    bus.blank_en = 1'b0;
    check_slot("mr_d3", 3, 4'h0, 1'b0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    check_slot("mr_d0b", 0, 4'h0, 1'b0, 1'b1, 1'b1, -1, 16'h0, 4'h0);

    // Free run from the start of a digit-1 slot.
    last_fd = -1; first_fd = -1; nfd = 0; nmulti = 0; nzero0 = 0; nen0 = 0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if ($countones(bus.digit_sel) > 1 || $countones(bus0.digit_sel) > 1) nmulti++;
      if (bus0.digit_sel == 4'b0000) nzero0++;
      if (!bus0.en) nen0++;
      if (bus.frame_done) begin
        nfd++;
        if (first_fd < 0) first_fd = t;
        if (last_fd >= 0) chk($sformatf("fd_period_t%0d", t), 32'(t - last_fd), 32'd32);
        last_fd = t;
      end
    end
    chk("fd_first", 32'(first_fd), 32'd25);
    chk("fd_count", 32'(nfd), 32'd3);
    chk("multihot", 32'(nmulti), 32'd0);
    chk("dead0_sel_zero", 32'(nzero0), 32'd0);
    chk("dead0_en_low", 32'(nen0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-segment multi-digit 7-segment display; directly upstream of the per-digit segment decoder.
- Holds a multi-digit hex value in a shadow register and walks one digit per refresh slot.
- Each slot emits the digit's nibble, decimal point and enable to the decoder, plus a one-hot digit-select to the display drivers.
- Inserts a dead-time blank at every slot start (anti-ghosting) and optionally suppresses leading zeros.

Parameters:
- NUM_DIGITS, 4: number of display digits (>=2).
- REFRESH_DIV, 50000: clk cycles per digit slot (>=2).
- DEAD_CYCLES, 500: blank cycles at start of each slot (0 <= DEAD_CYCLES < REFRESH_DIV).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex value; digit i = value[4i+3:4i], digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- load  in  1  captures value/dp_in into the shadow register on this edge.
- blank_en  in  1  leading-zero suppression enable.
- hex  out  4  nibble for the current digit.
- dp  out  1  decimal point for the current digit.
- en  out  1  decoder enable.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit select.
- frame_done  out  1  one-cycle pulse at each full-scan wrap.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- State:
  - prescaler p: $clog2(REFRESH_DIV) bits, counts 0..REFRESH_DIV-1 then wraps to 0.
  - digit index d: counts 0..NUM_DIGITS-1.
  - shadow register (value + dp).
  - active register (value + dp).
- Reset: p=0, d=0, shadow=0, active=0; all outputs 0 while reset is high and on the first cycle after release.
- Load: on an edge with load=1, shadow <= {value, dp_in}. It never alters the currently displayed slot.
- Slot boundary:
  - On the edge where p==REFRESH_DIV-1: p<=0, d<=d+1, wrapping NUM_DIGITS-1 -> 0, and active <= shadow.
  - If load is also high on that edge, active takes the old shadow; the new value appears from the following slot.
- Outputs are registered; they are derived from the registered p, d and active, with no combinational path from inputs.
  - Output in cycle n+1 reflects state in cycle n (1-cycle latency).
- Blank phase (p < DEAD_CYCLES): en=0, digit_sel=0, hex=0, dp=0.
- Drive phase (p >= DEAD_CYCLES):
  - digit_sel = 1<<d.
  - hex = active nibble d; dp = active dp[d].
  - en = 1 unless digit d is suppressed.
- Suppression (blank_en=1): digit d is suppressed iff all of the following hold:
  - d != 0;
  - active nibbles d..NUM_DIGITS-1 are all zero;
  - active dp[d..NUM_DIGITS-1] are all zero.
- A suppressed digit: digit_sel still asserted, en=0, hex=0, dp=0. blank_en is sampled combinationally into the output register each cycle.
- frame_done: 1 for exactly one cycle, aligned with the first blank-phase output cycle after d wraps to 0; period NUM_DIGITS*REFRESH_DIV cycles. It does not fire on reset release.
- DEAD_CYCLES=0: no blank phase; digit_sel is never all-zero outside reset.
- Reset mid-slot: counters return to 0 immediately on that edge; shadow/active cleared; the scan restarts at digit 0 with a blank phase.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2 unless noted):
- Reset release, then 8 cycles -> en=0/digit_sel=0 for 3 output cycles (reset latency + 2 dead), then digit_sel=4'b0001, hex=0, en=1 for 6 cycles, then blank.
- load with value=16'h1234, dp_in=4'b0010 mid-slot -> current slot unchanged; subsequent slots show d1:hex=3,dp=1; d2:hex=2; d3:hex=1; d0:hex=4 once active is updated.
- blank_en=1, value=16'h0050, dp_in=0 -> d3,d2 en=0 with digit_sel asserted; d1 hex=5,en=1; d0 hex=0,en=1. With dp_in=4'b0100 -> d2 en=1, hex=0, dp=1.
- load asserted on the p==7 edge with 16'hAAAA while shadow=16'h1111 -> next slot shows 1; the slot after shows A.
- reset pulsed at p=5 of digit 2 -> all outputs 0 next cycle; scan resumes at digit 0 with full blank phase; shadow reads 0.
- Free run 100 cycles -> frame_done pulses every 32 cycles, width 1; digit_sel never multi-hot; DEAD_CYCLES=0 run -> digit_sel never 0 after reset.
